keypad_operand_entry: RTL and testbench
=======================================

Name: keypad_operand_entry

Overview:
- Parametrised multi-operand keypad entry controller. Collects up to DIGITS decimal digits for each of NUM_OPERANDS operands from debounced key events.
- Supports backspace, clear and per-operand ENTER. Optionally converts the BCD operands to binary serially.
- Presents the result to the downstream calculator/ALU stage with a valid/ready handshake. Sits between the keypad scanner/debouncer and the arithmetic/display logic.

Parameters:
- NUM_OPERANDS, 2: number of operands collected per transaction (>=1).
- DIGITS, 4: max decimal digits per operand (1..8). Operand width OPW = 4*DIGITS.
- BIN_OUT, 1: 1 = operands output as unsigned binary (right-aligned in OPW); 0 = packed BCD.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle pulse per debounced key press
- key_code  in  4  key code, valid while key_valid=1
- out_ready  in  1  downstream accepts operands
- out_valid  out  1  operand set complete and stable
- operands  out  NUM_OPERANDS*OPW  operand i at bits [i*OPW +: OPW]
- live_bcd  out  OPW  BCD of the operand being entered (display)
- op_index  out  max(1,$clog2(NUM_OPERANDS))  operand currently being entered
- digit_count  out  $clog2(DIGITS+1)  digits held in the current operand
- operand_done  out  1  pulse: an operand was closed by ENTER
- overflow  out  1  pulse: digit rejected because the operand is full
- key_drop  out  1  pulse: key ignored because the block is busy
- busy  out  1  high in CONVERT or PRESENT

Behaviour:
- Key codes:
  - 0-9: digit.
  - 10 (A): ENTER.
  - 11 (B): BACKSPACE.
  - 12 (C): CLEAR.
  - 13-15: ignored silently, no pulse.
- Reset: state=ENTRY. All operand BCD/binary regs, live_bcd, op_index and digit_count are 0. out_valid, busy and all pulses are 0.
- All outputs are registered. Pulses last exactly one cycle, in the cycle after the key_valid edge.
- State ENTRY:
  - Digit with digit_count<DIGITS: BCD = {BCD[OPW-5:0], digit}; digit_count+1.
  - Digit with digit_count==DIGITS: no change; overflow=1.
  - BACKSPACE with digit_count>0: BCD shifted right 4 (zero-filled); digit_count-1.
  - BACKSPACE with digit_count==0: no-op. Never returns to the previous operand.
  - CLEAR: all operands zeroed, op_index=0, digit_count=0. Stays in ENTRY.
  - ENTER: operand_done=1. An empty operand is legal (value 0).
    - op_index<NUM_OPERANDS-1: op_index+1, digit_count=0.
    - Last operand, BIN_OUT=1: go to CONVERT.
    - Last operand, BIN_OUT=0: go to PRESENT.
- State CONVERT:
  - Exactly DIGITS cycles. All operands convert in parallel, MS digit first: acc = (acc<<3)+(acc<<1)+digit.
  - Then go to PRESENT.
  - Max value 10^DIGITS-1 always fits in OPW. No overflow is possible.
- State PRESENT:
  - out_valid=1; operands held stable.
  - On out_valid&&out_ready: next cycle out_valid=0, state=ENTRY, all operands/op_index/digit_count cleared.
  - out_ready already high on arrival: handshake completes in the first PRESENT cycle.
- Latency from the final ENTER edge to out_valid:
  - BIN_OUT=0: 1 cycle.
  - BIN_OUT=1: 1+DIGITS cycles.
- key_valid in CONVERT or PRESENT, including the handshake cycle: key ignored, key_drop=1.
- live_bcd tracks the current operand's BCD in ENTRY. It holds its last value in CONVERT/PRESENT.
- rst mid-operation, any state: immediate return to reset values. No partial output.
- operands in BCD mode reflect the stored BCD at all times. In binary mode they are valid only while out_valid=1.

Decomposition:
- Package keypad_pkg: key code constants (KEY_ENTER=10, KEY_BKSP=11, KEY_CLR=12), state enum {ENTRY, CONVERT, PRESENT}.
- Sub-module bcd_to_bin_serial (params DIGITS), one per operand, generated only when BIN_OUT=1.
  - Interface: start, bcd in, bin out, done after DIGITS cycles.
- The FSM, digit shift registers and counters stay in keypad_operand_entry.

Test Plan:
- Defaults (2 operands, 4 digits, BIN_OUT=1): keys 1,2,A,3,4,A -> operand_done pulses with op_index 0 then 1. out_valid 5 cycles after the last A. operands[15:0]=0x000C, operands[31:16]=0x0022.
- Keys 9,9,9,9,A,0,A -> operand0=0x270F, operand1=0x0000. Key 5 pressed after the four 9s -> overflow pulse, live_bcd stays 0x9999.
- BIN_OUT=0:
  - Keys 4,5,B,7 -> live_bcd=0x0047, digit_count=2.
  - B,B,B at count 0 -> live_bcd=0x0000, no underflow.
- Keys 1,A,2,3,C -> op_index=0, digit_count=0, operands all 0. Next A,A -> out_valid with both operands 0.
- out_ready low for 10 cycles in PRESENT with key 7 pulses -> key_drop pulses, out_valid held, operands unchanged. out_ready=1 -> next cycle out_valid=0, state ENTRY.
- rst asserted on cycle 2 of CONVERT -> all outputs 0 immediately. A following entry 5,A,6,A -> operands 5 and 6.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes and controller states for the keypad operand entry block
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam logic [3:0] KEY_BKSP  = 4'd11;
    localparam logic [3:0] KEY_CLR   = 4'd12;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        PRESENT = 2'd2
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_operand_entry_bcd_to_bin_serial.sv
// rtl/keypad_operand_entry_bcd_to_bin_serial.sv - serial packed-BCD to binary converter, one digit per cycle
module bcd_to_bin_serial
    import keypad_pkg::*;
#(
    parameter int DIGITS = 4,
    localparam int OPW   = 4 * DIGITS,
    localparam int CW    = $clog2(DIGITS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] bcd,
    output logic [OPW-1:0] bin,
    output logic           done
);

    logic [OPW-1:0] acc_q, acc_d;
    logic [OPW-1:0] sh_q, sh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;

    // The MS digit is absorbed on the start edge, so the last digit lands
    // DIGITS edges after start and done is a level held until the next start.
    always_comb begin
        acc_d  = acc_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (start) begin
            acc_d  = OPW'(bcd[OPW-1 -: 4]);
            sh_d   = bcd << 4;
            cnt_d  = CW'(DIGITS - 1);
            done_d = (DIGITS == 1);
        end else if (cnt_q != '0) begin
            acc_d  = (acc_q << 3) + (acc_q << 1) + OPW'(sh_q[OPW-1 -: 4]);
            sh_d   = sh_q << 4;
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bin  = acc_q;
    assign done = done_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// rtl/keypad_operand_entry.sv - multi-operand keypad entry controller with optional BCD-to-binary output
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int NUM_OPERANDS = 2,
    parameter int DIGITS       = 4,
    parameter int BIN_OUT      = 1,
    localparam int OPW         = 4 * DIGITS,
    localparam int OPI_W       = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
    localparam int CW          = $clog2(DIGITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    input  logic [3:0]                  key_code,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [NUM_OPERANDS*OPW-1:0] operands,
    output logic [OPW-1:0]              live_bcd,
    output logic [OPI_W-1:0]            op_index,
    output logic [CW-1:0]               digit_count,
    output logic                        operand_done,
    output logic                        overflow,
    output logic                        key_drop,
    output logic                        busy
);

    localparam logic [CW-1:0]    DIGITS_C = CW'(DIGITS);
    localparam logic [OPI_W-1:0] LAST_OP  = OPI_W'(NUM_OPERANDS - 1);

    state_e                             state_q, state_d;
    logic [NUM_OPERANDS-1:0][OPW-1:0]   bcd_q, bcd_d;
    logic [OPI_W-1:0]                   op_index_q, op_index_d;
    logic [CW-1:0]                      digit_count_q, digit_count_d;
    logic [OPW-1:0]                     live_bcd_q, live_bcd_d;
    logic                               out_valid_q, out_valid_d;
    logic                               operand_done_q, operand_done_d;
    logic                               overflow_q, overflow_d;
    logic                               key_drop_q, key_drop_d;
    logic                               busy_q, busy_d;
    logic                               conv_start;
    logic                               conv_done;

    always_comb begin
        state_d        = state_q;
        bcd_d          = bcd_q;
        op_index_d     = op_index_q;
        digit_count_d  = digit_count_q;
        out_valid_d    = out_valid_q;
        operand_done_d = 1'b0;
        overflow_d     = 1'b0;
        key_drop_d     = 1'b0;
        conv_start     = 1'b0;

        unique case (state_q)
            ENTRY: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (digit_count_q < DIGITS_C) begin
                            for (int i = 0; i < NUM_OPERANDS; i++) begin
                                if (op_index_q == OPI_W'(i)) begin
                                    bcd_d[i] = (bcd_q[i] << 4) | OPW'(key_code);
                                end
                            end
                            digit_count_d = digit_count_q + CW'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (key_code == KEY_BKSP) begin
                        if (digit_count_q != '0) begin
                            for (int i = 0; i < NUM_OPERANDS; i++) begin
                                if (op_index_q == OPI_W'(i)) begin
                                    bcd_d[i] = bcd_q[i] >> 4;
                                end
                            end
                            digit_count_d = digit_count_q - CW'(1);
                        end
                    end else if (key_code == KEY_CLR) begin
                        bcd_d         = '0;
                        op_index_d    = '0;
                        digit_count_d = '0;
                    end else if (key_code == KEY_ENTER) begin
                        operand_done_d = 1'b1;
                        if (op_index_q != LAST_OP) begin
                            op_index_d    = op_index_q + OPI_W'(1);
                            digit_count_d = '0;
                        end else if (BIN_OUT != 0) begin
                            state_d    = CONVERT;
                            conv_start = 1'b1;
                        end else begin
                            state_d     = PRESENT;
                            out_valid_d = 1'b1;
                        end
                    end
                end
            end
            CONVERT: begin
                key_drop_d = key_valid;
                if (conv_done) begin
                    state_d     = PRESENT;
                    out_valid_d = 1'b1;
                end
            end
            PRESENT: begin
                key_drop_d = key_valid;
                if (out_ready) begin
                    state_d       = ENTRY;
                    out_valid_d   = 1'b0;
                    bcd_d         = '0;
                    op_index_d    = '0;
                    digit_count_d = '0;
                end
            end
            default: state_d = ENTRY;
        endcase

        busy_d = (state_d != ENTRY);

        // The display follows whichever operand will be current next cycle,
        // and freezes once the block leaves ENTRY.
        live_bcd_d = live_bcd_q;
        if (state_d == ENTRY) begin
            live_bcd_d = '0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (op_index_d == OPI_W'(i)) begin
                    live_bcd_d = bcd_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ENTRY;
            bcd_q          <= '0;
            op_index_q     <= '0;
            digit_count_q  <= '0;
            live_bcd_q     <= '0;
            out_valid_q    <= 1'b0;
            operand_done_q <= 1'b0;
            overflow_q     <= 1'b0;
            key_drop_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bcd_q          <= bcd_d;
            op_index_q     <= op_index_d;
            digit_count_q  <= digit_count_d;
            live_bcd_q     <= live_bcd_d;
            out_valid_q    <= out_valid_d;
            operand_done_q <= operand_done_d;
            overflow_q     <= overflow_d;
            key_drop_q     <= key_drop_d;
            busy_q         <= busy_d;
        end
    end

    generate
        if (BIN_OUT != 0) begin : gen_bin
            logic [NUM_OPERANDS-1:0][OPW-1:0] bin_w;
            logic [NUM_OPERANDS-1:0]          done_w;
            logic [NUM_OPERANDS-1:0][OPW-1:0] op_bin_q, op_bin_d;

            for (genvar g = 0; g < NUM_OPERANDS; g++) begin : gen_conv
                bcd_to_bin_serial #(.DIGITS(DIGITS)) u_conv (
                    .clk   (clk),
                    .rst   (rst),
                    .start (conv_start),
                    .bcd   (bcd_q[g]),
                    .bin   (bin_w[g]),
                    .done  (done_w[g])
                );
            end

            assign conv_done = &done_w;

            // Binary results are captured on entry to PRESENT so the output
            // stays stable while the converters sit idle.
            always_comb begin
                op_bin_d = op_bin_q;
                if (state_q == CONVERT && conv_done) begin
                    op_bin_d = bin_w;
                end else if (state_q == PRESENT && out_ready) begin
                    op_bin_d = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    op_bin_q <= '0;
                end else begin
                    op_bin_q <= op_bin_d;
                end
            end

            assign operands = op_bin_q;
        end else begin : gen_bcd
            assign conv_done = 1'b0;
            assign operands  = bcd_q;
        end
    endgenerate

    assign out_valid    = out_valid_q;
    assign live_bcd     = live_bcd_q;
    assign op_index     = op_index_q;
    assign digit_count  = digit_count_q;
    assign operand_done = operand_done_q;
    assign overflow     = overflow_q;
    assign key_drop     = key_drop_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// tb/tb_keypad_operand_entry.sv - self-checking bench for keypad_operand_entry in binary and BCD modes
module tb_keypad_operand_entry;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        kv1, rdy1, ov1, od1, of1, kd1, busy1;
    logic [3:0]  kc1;
    logic [31:0] ops1;
    logic [15:0] live1;
    logic        opi1;
    logic [2:0]  dc1;

    logic        kv0, rdy0, ov0, od0, of0, kd0, busy0;
    logic [3:0]  kc0;
    logic [31:0] ops0;
    logic [15:0] live0;
    logic        opi0;
    logic [2:0]  dc0;

    keypad_operand_entry #(.NUM_OPERANDS(2), .DIGITS(4), .BIN_OUT(1)) u_bin (
        .clk(clk), .rst(rst), .key_valid(kv1), .key_code(kc1), .out_ready(rdy1),
        .out_valid(ov1), .operands(ops1), .live_bcd(live1), .op_index(opi1),
        .digit_count(dc1), .operand_done(od1), .overflow(of1), .key_drop(kd1), .busy(busy1)
    );

    keypad_operand_entry #(.NUM_OPERANDS(2), .DIGITS(4), .BIN_OUT(0)) u_bcd (
        .clk(clk), .rst(rst), .key_valid(kv0), .key_code(kc0), .out_ready(rdy0),
        .out_valid(ov0), .operands(ops0), .live_bcd(live0), .op_index(opi0),
        .digit_count(dc0), .operand_done(od0), .overflow(of0), .key_drop(kd0), .busy(busy0)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          nk;
        logic [3:0]  keys [8];
        logic [15:0] exp0;
        logic [15:0] exp1;
        int          novf;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input bit bin, input logic [3:0] code);
        @(negedge clk);
        if (bin) begin
            kv1 = 1'b1;
            kc1 = code;
        end else begin
            kv0 = 1'b1;
            kc0 = code;
        end
        @(negedge clk);
        kv1 = 1'b0;
        kv0 = 1'b0;
    endtask

    task automatic finish_bin(input string name);
        int cyc;
        logic [31:0] e;
        cyc = 1;
        while (!ov1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, cyc, 32'd5);
        check({name, " busy"}, {31'b0, busy1}, 32'd1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard: got empty queue required an entry", name);
        end else begin
            e = exp_q.pop_front();
            check({name, " operands"}, ops1, e);
        end
        @(negedge clk);
        check({name, " released"}, {30'b0, ov1, busy1}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int novf;
        int nod;
        int nent;
        rst  = 1'b1;
        kv1  = 1'b0; kc1 = 4'd0; rdy1 = 1'b1;
        kv0  = 1'b0; kc0 = 4'd0; rdy0 = 1'b0;

        vecs[0] = '{nk: 6, keys: '{4'd1, 4'd2, 4'd10, 4'd3, 4'd4, 4'd10, 4'd0, 4'd0},
                    exp0: 16'h000C, exp1: 16'h0022, novf: 0};
        vecs[1] = '{nk: 8, keys: '{4'd9, 4'd9, 4'd9, 4'd9, 4'd5, 4'd10, 4'd0, 4'd10},
                    exp0: 16'h270F, exp1: 16'h0000, novf: 1};
        vecs[2] = '{nk: 7, keys: '{4'd1, 4'd10, 4'd2, 4'd3, 4'd12, 4'd10, 4'd10, 4'd0},
                    exp0: 16'h0000, exp1: 16'h0000, novf: 0};
        vecs[3] = '{nk: 8, keys: '{4'd8, 4'd7, 4'd11, 4'd6, 4'd10, 4'd1, 4'd0, 4'd10},
                    exp0: 16'h0056, exp1: 16'h000A, novf: 0};
        vecs[4] = '{nk: 6, keys: '{4'd10, 4'd9, 4'd0, 4'd0, 4'd1, 4'd10, 4'd0, 4'd0},
                    exp0: 16'h0000, exp1: 16'h2329, novf: 0};

        repeat (3) @(negedge clk);
        check("reset bin flags", {28'b0, ov1, busy1, od1, of1}, 32'd0);
        check("reset bin regs", {11'b0, opi1, dc1, live1}, 32'd0);
        check("reset bin operands", ops1, 32'd0);
        check("reset bcd regs", {9'b0, ov0, busy0, kd0, opi0, dc0, live0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            exp_q.push_back({vecs[v].exp1, vecs[v].exp0});
            novf = 0;
            nod  = 0;
            nent = 0;
            for (int k = 0; k < vecs[v].nk; k++) begin
                press(1'b1, vecs[v].keys[k]);
                novf += int'(of1);
                nod  += int'(od1);
                if (vecs[v].keys[k] == 4'd10) nent++;
                if (v == 0 && k == 2) check("vec0 op_index after first enter", {31'b0, opi1}, 32'd1);
                if (v == 1 && k == 4) check("vec1 live after overflow", {16'b0, live1}, 32'h9999);
            end
            check($sformatf("vec%0d overflow pulses", v), novf, vecs[v].novf);
            check($sformatf("vec%0d operand_done pulses", v), nod, nent);
            finish_bin($sformatf("vec%0d", v));
        end

        press(1'b0, 4'd4); press(1'b0, 4'd5); press(1'b0, 4'd11); press(1'b0, 4'd7);
        check("bksp live", {16'b0, live0}, 32'h0047);
        check("bksp count", {29'b0, dc0}, 32'd2);
        press(1'b0, 4'd11); press(1'b0, 4'd11); press(1'b0, 4'd11);
        check("bksp underflow", {13'b0, dc0, live0}, 32'd0);

        for (int k = 0; k < 4; k++) press(1'b0, 4'd9);
        check("full live", {16'b0, live0}, 32'h9999);
        press(1'b0, 4'd5);
        check("overflow pulse", {31'b0, of0}, 32'd1);
        check("overflow keeps live", {13'b0, dc0, live0}, {13'b0, 3'd4, 16'h9999});
        press(1'b0, 4'd10);
        check("enter0 pulse/index", {30'b0, od0, opi0}, 32'd3);
        check("enter0 new operand", {13'b0, dc0, live0}, 32'd0);
        check("bcd operands live", ops0, 32'h0000_9999);
        press(1'b0, 4'd1);
        check("bcd operand1", ops0, 32'h0001_9999);
        exp_q.push_back(32'h0001_9999);
        press(1'b0, 4'd10);
        check("bcd latency 1", {29'b0, ov0, od0, busy0}, 32'd7);
        check("live holds in present", {16'b0, live0}, 32'h0001);
        for (int k = 0; k < 10; k++) begin
            press(1'b0, 4'd7);
            check($sformatf("hold %0d", k), {kd0, ov0, 14'b0, ops0[15:0]}, {2'b11, 14'b0, 16'h9999});
            check($sformatf("hold %0d hi", k), ops0, 32'h0001_9999);
        end
        @(negedge clk);
        check("key_drop single cycle", {31'b0, kd0}, 32'd0);
        rdy0 = 1'b1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bcd scoreboard: got empty queue required an entry");
        end else begin
            check("bcd handshake operands", ops0, exp_q.pop_front());
        end
        @(negedge clk);
        rdy0 = 1'b0;
        check("bcd after handshake", {13'b0, ov0, busy0, opi0, dc0, 12'b0}, 32'd0);
        check("bcd operands cleared", ops0, 32'd0);

        press(1'b1, 4'd1); press(1'b1, 4'd10); press(1'b1, 4'd2); press(1'b1, 4'd10);
        check("convert entered", {31'b0, busy1}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst mid convert flags", {28'b0, ov1, busy1, od1, kd1}, 32'd0);
        check("rst mid convert regs", {11'b0, opi1, dc1, live1}, 32'd0);
        check("rst mid convert operands", ops1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({16'h0006, 16'h0005});
        press(1'b1, 4'd5); press(1'b1, 4'd10); press(1'b1, 4'd6); press(1'b1, 4'd10);
        finish_bin("after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
